// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared types, code tables and helpers for the TMDS channel
//                encoder (mode enum, CTRL/TERC4/guard-band symbols, popcount).
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

   // Encoding mode presented by the video timing / packet mux
   typedef enum logic [1:0] {
      MODE_CTRL  = 2'd0,
      MODE_VIDEO = 2'd1,
      MODE_DATA  = 2'd2,
      MODE_GUARD = 2'd3
   } tmds_mode_e;

   // Control-period symbols indexed by {C1,C0}
   localparam logic [9:0] CTRL_CODES [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   // TERC4 data-island symbols indexed by the 4-bit nibble
   localparam logic [9:0] TERC4_CODES [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   // Guard-band symbols: video guard for lanes 0/2 and 1, data-island guard for lanes 1/2
   localparam logic [9:0] VGB_CODE_02 = 10'b1011001100;
   localparam logic [9:0] VGB_CODE_1  = 10'b0100110011;
   localparam logic [9:0] DGB_CODE_12 = 10'b0100110011;

   // Number of set bits in a byte
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_qm_stage
//  Description : Combinational transition-minimisation of one pixel byte into
//                the 9-bit q_m word, plus the ones count of q_m[7:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic [7:0] i_data,
   output logic [8:0] o_qm,
   output logic [3:0] o_n1
);

   logic [3:0] w_ones;
   logic       w_use_xnor;
   logic [8:0] w_qm;

   // XNOR chaining yields fewer transitions for dense bytes; ties broken by d[0]
   assign w_ones     = popcount8(i_data);
   assign w_use_xnor = (w_ones > 4'd4) || ((w_ones == 4'd4) && !i_data[0]);

   // Build q_m bit by bit; q_m[8] records which chaining was used (1 = XOR)
   always_comb begin
      w_qm    = '0;
      w_qm[0] = i_data[0];
      for (int i = 1; i < 8; i++) begin
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
      end
      w_qm[8] = ~w_use_xnor;
   end

   assign o_qm = w_qm;
   assign o_n1 = popcount8(w_qm[7:0]);

endmodule
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_channel_encoder
//  Description : Two-stage TMDS lane encoder: DVI video with running
//                disparity, CTRL codes, TERC4 data islands and guard bands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL = 0,
   parameter int CNT_W   = 5
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic [1:0]       i_mode,
   input  logic [7:0]       i_data,
   input  logic [1:0]       i_ctrl,
   input  logic [3:0]       i_terc4,
   output logic [9:0]       o_tmds,
   output logic [CNT_W-1:0] o_disparity
);

   generate
      if (CNT_W < 5) begin : g_cnt_w_check
         $error("tmds_channel_encoder: CNT_W must be at least 5");
      end
      if ((CHANNEL < 0) || (CHANNEL > 2)) begin : g_channel_check
         $error("tmds_channel_encoder: CHANNEL must be 0, 1 or 2");
      end
   endgenerate

   localparam logic signed [CNT_W-1:0] c_eight    = CNT_W'(8);
   localparam logic signed [CNT_W-1:0] c_two      = CNT_W'(2);
   localparam logic [9:0]              c_vgb_code = (CHANNEL == 1) ? VGB_CODE_1 : VGB_CODE_02;

   // Stage 1 state
   tmds_mode_e r_mode;
   logic [1:0] r_ctrl;
   logic [3:0] r_terc4;
   logic [8:0] r_qm;
   logic [3:0] r_n1;

   // Stage 2 state
   logic [9:0]              r_tmds;
   logic signed [CNT_W-1:0] r_cnt;

   logic [8:0]              w_qm;
   logic [3:0]              w_n1;
   logic [9:0]              w_sym;
   logic signed [CNT_W-1:0] w_cnt_nxt;
   logic signed [CNT_W-1:0] w_diff;
   logic signed [CNT_W-1:0] w_qm8x2;
   logic signed [CNT_W-1:0] w_nqm8x2;
   logic                    w_cnt_pos;
   logic                    w_cnt_neg;

   tmds_qm_stage u_qm (
      .i_data (i_data),
      .o_qm   (w_qm),
      .o_n1   (w_n1)
   );

   // Stage 1: capture mode/side-band inputs alongside the minimised byte
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode  <= MODE_CTRL;
         r_ctrl  <= '0;
         r_terc4 <= '0;
         r_qm    <= '0;
         r_n1    <= '0;
      end else if (i_ce) begin
         r_mode  <= tmds_mode_e'(i_mode);
         r_ctrl  <= i_ctrl;
         r_terc4 <= i_terc4;
         r_qm    <= w_qm;
         r_n1    <= w_n1;
      end
   end

   // N1 - N0 = 2*N1 - 8; the q_m[8] terms feed the biased correction branches
   assign w_diff    = $signed(CNT_W'({r_n1, 1'b0})) - c_eight;
   assign w_qm8x2   = r_qm[8] ? c_two : '0;
   assign w_nqm8x2  = r_qm[8] ? '0 : c_two;
   assign w_cnt_neg = r_cnt[CNT_W-1];
   assign w_cnt_pos = !r_cnt[CNT_W-1] && (r_cnt != '0);

   // Stage 2 symbol selection and next running disparity
   always_comb begin
      w_sym     = CTRL_CODES[0];
      w_cnt_nxt = '0;
      case (r_mode)
         MODE_VIDEO: begin
            if ((r_cnt == '0) || (r_n1 == 4'd4)) begin
               w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
               w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
            end else if ((w_cnt_pos && (r_n1 > 4'd4)) || (w_cnt_neg && (r_n1 < 4'd4))) begin
               w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
               w_cnt_nxt = r_cnt + w_qm8x2 - w_diff;
            end else begin
               w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
               w_cnt_nxt = r_cnt - w_nqm8x2 + w_diff;
            end
         end
         MODE_CTRL: w_sym = CTRL_CODES[r_ctrl];
         MODE_DATA: w_sym = TERC4_CODES[r_terc4];
         MODE_GUARD: begin
            if (!r_terc4[0]) begin
               w_sym = c_vgb_code;
            end else if (CHANNEL == 0) begin
               w_sym = TERC4_CODES[{2'b11, r_ctrl}];
            end else begin
               w_sym = DGB_CODE_12;
            end
         end
         default: w_sym = CTRL_CODES[0];
      endcase
   end

   // Stage 2: register the symbol and disparity; non-video symbols zero the count
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmds <= CTRL_CODES[0];
         r_cnt  <= '0;
      end else if (i_ce) begin
         r_tmds <= w_sym;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_tmds      = r_tmds;
   assign o_disparity = r_cnt;

endmodule
`default_nettype wire
